// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: fault codes, the queued
// fetch entry and the fault-priority decode.
package fetch_pkg;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_ACCESS   = 2'd2
    } fault_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        fault_e      fault;
    } fetch_entry_t;

    // Misalignment is decided by the PC alone and outranks a bus error.
    function automatic fault_e fault_decode(input logic [1:0] pc_lsb, input logic err);
        if (pc_lsb != 2'b00) return FAULT_MISALIGN;
        if (err)             return FAULT_ACCESS;
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode handshake: one fetch entry per valid/ready transfer.
interface fetch_if;
    import fetch_pkg::*;

    logic         valid;
    logic         ready;
    fetch_entry_t entry;

    modport master (output valid, output entry, input ready);
    modport slave  (input valid, input entry, output ready);

endinterface

// File: rtl/fetch_fifo.sv
// Circular fetch buffer with synchronous flush; the head is read straight
// from storage so the outputs toward decode are registered.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic empty_o,
    output logic full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !flush_i));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues the PC to a 1-cycle synchronous imem, tags each
// returned word with its PC/fault and buffers it toward decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        pc_stall_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    fetch_if.master     id_if
);

    logic [31:0]  pc_q;
    logic         inflight_q;
    logic         fifo_full, fifo_empty;
    logic         push, pop;
    fault_e       rsp_fault;
    fetch_entry_t rsp_entry;

    // The memory is read every cycle we are out of reset; stalls are handled
    // by dropping the response and letting the held PC re-fetch it.
    assign imem_en_o   = rst_ni;
    assign imem_addr_o = {pc_i[31:2], 2'b00};
    assign next_pc_o   = redirect_i ? redirect_pc_i : pc_i + 32'd4;

    // Stall comes only from registered occupancy, so there is no path from
    // id_ready to the PC stage; a redirect must be allowed to load the target.
    assign pc_stall_o = fifo_full & ~redirect_i;

    assign push = inflight_q & ~fifo_full & ~redirect_i;
    assign pop  = id_if.valid & id_if.ready & ~redirect_i;

    always_comb begin
        rsp_fault       = fault_decode(pc_q[1:0], imem_err_i);
        rsp_entry       = '0;
        rsp_entry.pc    = pc_q;
        rsp_entry.fault = rsp_fault;
        rsp_entry.instr = (rsp_fault == FAULT_NONE) ? imem_rdata_i : NOP_INSTR;
    end

    // inflight_q marks the next cycle's response as on the correct path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q       <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_i;
            inflight_q <= ~redirect_i;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  (rsp_entry),
        .pop_i   (pop),
        .data_o  (id_if.entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign id_if.valid = ~fifo_empty;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed vectors push expected entries,
// a monitor pops and compares on every decode handshake.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc, next_pc, redir_pc, imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;
    logic        stall, redir, imem_en;
    logic        err_en;
    logic [31:0] err_addr;

    int n_vec = 0;
    int n_err = 0;
    fetch_entry_t exp_q[$];

    fetch_if id_if();

    fetch_stage #(.BUF_DEPTH(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pc_i          (pc),
        .next_pc_o     (next_pc),
        .pc_stall_o    (stall),
        .redirect_i    (redir),
        .redirect_pc_i (redir_pc),
        .imem_en_o     (imem_en),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .imem_err_i    (imem_err),
        .id_if         (id_if)
    );

    always #5 clk = ~clk;

    // PC stage: advances to next_pc when not stalled; while stalled it shows
    // the PC it presented on the previous cycle.
    logic [31:0] pc_p, pc_l;
    assign pc = stall ? pc_l : pc_p;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p <= '0;
            pc_l <= '0;
        end else begin
            pc_l <= pc;
            if (!stall) pc_p <= next_pc;
        end
    end

    // Instruction memory: data equals the word address, optional error address.
    always @(posedge clk) begin
        if (imem_en) begin
            imem_rdata <= imem_addr;
            imem_err   <= err_en && (imem_addr == err_addr);
        end
    end

    // Monitor: a transfer happens on the next posedge when valid&ready and no redirect.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n && id_if.valid && id_if.ready && !redir) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_entry: got pc=%h instr=%h fault=%0d, required no entry",
                             id_if.entry.pc, id_if.entry.instr, id_if.entry.fault);
                end else begin
                    e = exp_q.pop_front();
                    if (id_if.entry !== e) begin
                        n_err++;
                        $display("FAIL entry: got pc=%h instr=%h fault=%0d, required pc=%h instr=%h fault=%0d",
                                 id_if.entry.pc, id_if.entry.instr, id_if.entry.fault,
                                 e.pc, e.instr, e.fault);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_entry(input logic [31:0] p, input logic [31:0] i, input fault_e f);
        fetch_entry_t e;
        e.pc = p;
        e.instr = i;
        e.fault = f;
        exp_q.push_back(e);
    endtask

    // Hold ready high until every expected entry was taken, then drop it.
    task automatic drain(input bit chk_stall);
        int k;
        k = 0;
        @(posedge clk);
        #1 id_if.ready = 1'b1;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            if (chk_stall) chk("stall_low", {31'b0, stall}, 32'd0);
            @(posedge clk);
            k++;
        end
        #1 id_if.ready = 1'b0;
        if (exp_q.size() != 0) begin
            chk("drain_timeout_left", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        @(posedge clk);
        #1 redir = 1'b1;
        redir_pc = tgt;
        @(negedge clk);
        chk("redirect_next_pc", next_pc, tgt);
        chk("redirect_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1 redir = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'b0, id_if.valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        id_if.ready = 1'b0;
        redir = 1'b0;
        redir_pc = '0;
        err_en = 1'b0;
        err_addr = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", {31'b0, id_if.valid}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
        chk("rst_pc", id_if.entry.pc, 32'd0);
        chk("rst_instr", id_if.entry.instr, 32'd0);
        chk("rst_fault", {30'b0, id_if.entry.fault}, 32'd0);

        // 1: streaming from reset, one entry per cycle, never stalls
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("imem_en_run", {31'b0, imem_en}, 32'd1);
        for (int i = 0; i < 8; i++) expect_entry(32'(i * 4), 32'(i * 4), FAULT_NONE);
        drain(1'b1);

        // 2: back-pressure from a fresh reset fills the buffer, no gap/duplicate
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("full_stall", {31'b0, stall}, 32'd1);
        chk("full_valid", {31'b0, id_if.valid}, 32'd1);
        chk("full_head_pc", id_if.entry.pc, 32'h0);
        for (int i = 0; i < 6; i++) expect_entry(32'(i * 4), 32'(i * 4), FAULT_NONE);
        drain(1'b0);

        // 3: redirect while full kills buffered and in-flight wrong-path words
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_redirect_stall", {31'b0, stall}, 32'd1);
        redirect_to(32'h100);
        for (int i = 0; i < 4; i++) expect_entry(32'h100 + 32'(i * 4), 32'h100 + 32'(i * 4), FAULT_NONE);
        drain(1'b0);

        // 4: misaligned target
        redirect_to(32'h102);
        expect_entry(32'h102, NOP_INSTR, FAULT_MISALIGN);
        expect_entry(32'h106, NOP_INSTR, FAULT_MISALIGN);
        drain(1'b0);

        // 5: access error on one word only
        err_en = 1'b1;
        err_addr = 32'h8;
        redirect_to(32'h0);
        expect_entry(32'h0, 32'h0, FAULT_NONE);
        expect_entry(32'h4, 32'h4, FAULT_NONE);
        expect_entry(32'h8, NOP_INSTR, FAULT_ACCESS);
        expect_entry(32'hC, 32'hC, FAULT_NONE);
        expect_entry(32'h10, 32'h10, FAULT_NONE);
        drain(1'b0);
        err_en = 1'b0;

        // 6: PC wrap, then async reset in the middle of a stall
        redirect_to(32'hFFFF_FFFC);
        chk("wrap_next_pc", next_pc, 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("wrap_stall", {31'b0, stall}, 32'd1);
        chk("wrap_head_pc", id_if.entry.pc, 32'hFFFF_FFFC);
        chk("wrap_head_instr", id_if.entry.instr, 32'hFFFF_FFFC);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, id_if.valid}, 32'd0);
        chk("async_rst_stall", {31'b0, stall}, 32'd0);
        chk("async_rst_imem_en", {31'b0, imem_en}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expect_entry(32'h0, 32'h0, FAULT_NONE);
        expect_entry(32'h4, 32'h4, FAULT_NONE);
        drain(1'b0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
